// File: rtl/nb_chain_pkg.sv
// Shared mode encoding for the nonblocking register chain.
package nb_chain_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_RECIRC = 2'b01,
        MODE_SWAP   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

endpackage

// File: rtl/nb_chain_stage.sv
// One chain stage: CH channels of WIDTH bits plus a valid bit.
// Loads the shift source, or rotates its own channels by one position.
module nb_chain_stage
    import nb_chain_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CH    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic                  rot_i,
    input  logic [CH*WIDTH-1:0]   d_i,
    input  logic                  vld_i,
    output logic [CH*WIDTH-1:0]   q_o,
    output logic                  vld_o
);

    logic [CH*WIDTH-1:0] q_q;
    logic [CH*WIDTH-1:0] q_d;
    logic [CH*WIDTH-1:0] rot_w;
    logic                vld_q;
    logic                vld_d;

    // Channel c takes channel c+1; the top channel wraps to channel 0.
    always_comb begin
        rot_w = q_q;
        for (int c = 0; c < CH; c++) begin
            rot_w[c*WIDTH +: WIDTH] = q_q[((c + 1) % CH)*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        q_d   = q_q;
        vld_d = vld_q;
        if (clear_i) begin
            q_d   = '0;
            vld_d = 1'b0;
        end else if (en_i) begin
            if (rot_i) begin
                q_d = rot_w;
            end else begin
                q_d   = d_i;
                vld_d = vld_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            vld_q <= vld_d;
        end
    end

    assign q_o   = q_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/nb_shift_chain.sv
// Multi-channel register chain with shift, ring recirculation, channel
// rotation and hold modes; tracks per-stage valids and an occupancy count.
module nb_shift_chain
    import nb_chain_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CH    = 2,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_i,
    input  logic                         flush_i,
    input  logic [1:0]                   mode_i,
    input  logic [CH*WIDTH-1:0]          data_i,
    input  logic                         valid_i,
    output logic [CH*WIDTH-1:0]          data_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    mode_t               mode;
    logic                advance;
    logic                rot;
    logic [CH*WIDTH-1:0] head_d;
    logic                head_v;
    logic [CH*WIDTH-1:0] stage_q [DEPTH];
    logic [DEPTH-1:0]    vld_w;
    logic [OCC_W-1:0]    occ_q;
    logic [OCC_W-1:0]    occ_d;

    assign mode    = mode_t'(mode_i);
    assign advance = en_i && (mode != MODE_HOLD);
    assign rot     = (mode == MODE_SWAP);

    // Stage 0 is fed from the input word, or from the last stage to close the ring.
    assign head_d = (mode == MODE_RECIRC) ? stage_q[DEPTH-1] : data_i;
    assign head_v = (mode == MODE_RECIRC) ? vld_w[DEPTH-1]   : valid_i;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [CH*WIDTH-1:0] src_d;
        logic                src_v;
        if (k == 0) begin : g_head
            assign src_d = head_d;
            assign src_v = head_v;
        end else begin : g_body
            assign src_d = stage_q[k-1];
            assign src_v = vld_w[k-1];
        end

        nb_chain_stage #(
            .WIDTH (WIDTH),
            .CH    (CH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear_i (flush_i),
            .en_i    (advance),
            .rot_i   (rot),
            .d_i     (src_d),
            .vld_i   (src_v),
            .q_o     (stage_q[k]),
            .vld_o   (vld_w[k])
        );
    end

    // Only SHIFT moves valids into or out of the chain; bounded by DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else if (en_i && (mode == MODE_SHIFT)) begin
            occ_d = occ_q + OCC_W'(valid_i) - OCC_W'(vld_w[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign data_o  = stage_q[DEPTH-1];
    assign valid_o = vld_w[DEPTH-1];
    assign occ_o   = occ_q;

endmodule

// File: tb/tb_nb_shift_chain.sv
// Directed bench for nb_shift_chain: two configurations share one reset and
// one expected queue; a monitor pops and compares once per cycle.
module tb_nb_shift_chain;
    import nb_chain_pkg::*;

    localparam int EW = 17;  // {sel, data[11:0], valid, occ[2:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_en = 1'b0, a_flush = 1'b0, a_valid = 1'b0;
    logic [1:0]  a_mode = 2'b00;
    logic [1:0]  a_data = '0;
    logic [1:0]  a_data_o;
    logic        a_valid_o;
    logic [1:0]  a_occ_o;

    logic        b_en = 1'b0, b_flush = 1'b0, b_valid = 1'b0;
    logic [1:0]  b_mode = 2'b00;
    logic [11:0] b_data = '0;
    logic [11:0] b_data_o;
    logic        b_valid_o;
    logic [2:0]  b_occ_o;

    logic [EW-1:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_step = 0;

    always #5 clk = ~clk;

    nb_shift_chain #(.WIDTH(1), .CH(2), .DEPTH(2)) dut_a (
        .clk (clk), .rst_n (rst_n), .en_i (a_en), .flush_i (a_flush),
        .mode_i (a_mode), .data_i (a_data), .valid_i (a_valid),
        .data_o (a_data_o), .valid_o (a_valid_o), .occ_o (a_occ_o)
    );

    nb_shift_chain #(.WIDTH(4), .CH(3), .DEPTH(4)) dut_b (
        .clk (clk), .rst_n (rst_n), .en_i (b_en), .flush_i (b_flush),
        .mode_i (b_mode), .data_i (b_data), .valid_i (b_valid),
        .data_o (b_data_o), .valid_o (b_valid_o), .occ_o (b_occ_o)
    );

    task automatic step_a(input logic rst, input logic en, input logic fl,
                          input logic [1:0] mode, input logic [1:0] d, input logic v,
                          input logic [1:0] ed, input logic ev, input logic [1:0] eo);
        rst_n = rst; a_en = en; a_flush = fl; a_mode = mode; a_data = d; a_valid = v;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 10'd0, ed, ev, 1'b0, eo});
        @(negedge clk);
    endtask

    task automatic step_b(input logic rst, input logic en, input logic fl,
                          input logic [1:0] mode, input logic [11:0] d, input logic v,
                          input logic [11:0] ed, input logic ev, input logic [2:0] eo);
        rst_n = rst; b_en = en; b_flush = fl; b_mode = mode; b_data = d; b_valid = v;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b1, ed, ev, eo});
        @(negedge clk);
    endtask

    // Monitor: one expectation per cycle, compared on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            logic [11:0]   got_d;
            logic          got_v;
            logic [2:0]    got_o;
            e = exp_q.pop_front();
            n_step++;
            if (e[16]) begin
                got_d = b_data_o; got_v = b_valid_o; got_o = b_occ_o;
            end else begin
                got_d = {10'd0, a_data_o}; got_v = a_valid_o; got_o = {1'b0, a_occ_o};
            end
            n_checks++;
            if (got_d !== e[15:4]) begin
                n_fail++;
                $display("FAIL step%0d %s data_o got %h expected %h", n_step, e[16] ? "b" : "a", got_d, e[15:4]);
            end
            n_checks++;
            if (got_v !== e[3]) begin
                n_fail++;
                $display("FAIL step%0d %s valid_o got %b expected %b", n_step, e[16] ? "b" : "a", got_v, e[3]);
            end
            n_checks++;
            if (got_o !== e[2:0]) begin
                n_fail++;
                $display("FAIL step%0d %s occ_o got %0d expected %0d", n_step, e[16] ? "b" : "a", got_o, e[2:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with aggressive inputs, then shift latency on the 2-stage chain
        step_a(0, 1, 0, MODE_SHIFT, 2'b11, 1, 2'b00, 0, 2'd0);
        step_a(0, 1, 0, MODE_SHIFT, 2'b11, 1, 2'b00, 0, 2'd0);
        step_a(1, 1, 0, MODE_SHIFT, 2'b01, 1, 2'b00, 0, 2'd1);
        step_a(1, 1, 0, MODE_SHIFT, 2'b00, 0, 2'b01, 1, 2'd1);
        step_a(1, 1, 0, MODE_SHIFT, 2'b00, 0, 2'b00, 0, 2'd0);
        // Data captured with valid low, then a/b swap
        step_a(1, 1, 0, MODE_SHIFT, 2'b10, 0, 2'b00, 0, 2'd0);
        step_a(1, 1, 0, MODE_SHIFT, 2'b00, 0, 2'b10, 0, 2'd0);
        step_a(1, 1, 0, MODE_SWAP,  2'b11, 1, 2'b01, 0, 2'd0);
        a_en = 1'b0;

        // 4-stage, 3-channel chain: load {3,2,1}
        step_b(1, 1, 0, MODE_SHIFT, 12'h321, 1, 12'h000, 0, 3'd1);
        step_b(1, 1, 0, MODE_SHIFT, 12'h000, 0, 12'h000, 0, 3'd1);
        step_b(1, 1, 0, MODE_SHIFT, 12'h000, 0, 12'h000, 0, 3'd1);
        step_b(1, 1, 0, MODE_SHIFT, 12'h000, 0, 12'h321, 1, 3'd1);
        // Channel rotation, data_i ignored
        step_b(1, 1, 0, MODE_SWAP,  12'hFFF, 1, 12'h132, 1, 3'd1);
        step_b(1, 1, 0, MODE_SWAP,  12'hFFF, 1, 12'h213, 1, 3'd1);
        step_b(1, 1, 0, MODE_SWAP,  12'hFFF, 1, 12'h321, 1, 3'd1);
        // Shift in 1..4; the old 321 leaves on the first edge
        step_b(1, 1, 0, MODE_SHIFT, 12'h001, 1, 12'h000, 0, 3'd1);
        step_b(1, 1, 0, MODE_SHIFT, 12'h002, 1, 12'h000, 0, 3'd2);
        step_b(1, 1, 0, MODE_SHIFT, 12'h003, 1, 12'h000, 0, 3'd3);
        step_b(1, 1, 0, MODE_SHIFT, 12'h004, 1, 12'h001, 1, 3'd4);
        // Ring recirculation
        step_b(1, 1, 0, MODE_RECIRC, 12'hFFF, 1, 12'h002, 1, 3'd4);
        step_b(1, 1, 0, MODE_RECIRC, 12'hFFF, 1, 12'h003, 1, 3'd4);
        step_b(1, 1, 0, MODE_RECIRC, 12'hFFF, 1, 12'h004, 1, 3'd4);
        step_b(1, 1, 0, MODE_RECIRC, 12'hFFF, 1, 12'h001, 1, 3'd4);
        step_b(1, 1, 0, MODE_RECIRC, 12'hFFF, 1, 12'h002, 1, 3'd4);
        // Enable low and HOLD mode freeze state
        step_b(1, 0, 0, MODE_SHIFT, 12'hFFF, 1, 12'h002, 1, 3'd4);
        step_b(1, 0, 0, MODE_SHIFT, 12'hFFF, 1, 12'h002, 1, 3'd4);
        step_b(1, 0, 0, MODE_SHIFT, 12'hFFF, 1, 12'h002, 1, 3'd4);
        step_b(1, 1, 0, MODE_HOLD,  12'hFFF, 1, 12'h002, 1, 3'd4);
        // Flush with enable low, then flush together with reset
        step_b(1, 0, 1, MODE_SHIFT, 12'hFFF, 1, 12'h000, 0, 3'd0);
        step_b(1, 1, 0, MODE_SHIFT, 12'h0AB, 1, 12'h000, 0, 3'd1);
        step_b(0, 1, 1, MODE_SHIFT, 12'hFFF, 1, 12'h000, 0, 3'd0);
        // Reset mid-stream at occupancy 3, then full-latency restart
        step_b(1, 1, 0, MODE_SHIFT, 12'h005, 1, 12'h000, 0, 3'd1);
        step_b(1, 1, 0, MODE_SHIFT, 12'h006, 1, 12'h000, 0, 3'd2);
        step_b(1, 1, 0, MODE_SHIFT, 12'h007, 1, 12'h000, 0, 3'd3);
        step_b(0, 1, 0, MODE_SHIFT, 12'hFFF, 1, 12'h000, 0, 3'd0);
        step_b(1, 1, 0, MODE_SHIFT, 12'h9A5, 1, 12'h000, 0, 3'd1);
        step_b(1, 1, 0, MODE_SHIFT, 12'h000, 0, 12'h000, 0, 3'd1);
        step_b(1, 1, 0, MODE_SHIFT, 12'h000, 0, 12'h000, 0, 3'd1);
        step_b(1, 1, 0, MODE_SHIFT, 12'h000, 0, 12'h9A5, 1, 3'd1);
        step_b(1, 1, 0, MODE_SHIFT, 12'h000, 0, 12'h000, 0, 3'd0);
        b_en = 1'b0;

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending got %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nb_shift_chain.md
Name: nb_shift_chain

Overview:
- Parametrised multi-channel register chain built on nonblocking semantics.
- Generalises a two-flop a/b transfer to CH channels of WIDTH bits through DEPTH stages.
- Four modes: shift-in pipeline, stage recirculation (ring), per-stage channel rotation (swap), and hold.
- Used as a configurable delay/reorder element between datapath blocks. Per-stage valid tracking and an occupancy count.

Parameters:
- WIDTH, 1, bits per channel (>=1)
- CH, 2, channels per stage (>=1)
- DEPTH, 2, number of register stages (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low (sampled on rising clk edge)
- en_i  input  1  advance enable; 0 = hold all state
- flush_i  input  1  synchronous clear of all stages, valids and occupancy
- mode_i  input  2  00 SHIFT, 01 RECIRC, 10 SWAP, 11 HOLD
- data_i  input  CH*WIDTH  input word; channel c occupies bits [c*WIDTH +: WIDTH]
- valid_i  input  1  qualifies data_i in SHIFT mode
- data_o  output  CH*WIDTH  contents of stage[DEPTH-1] (direct register output)
- valid_o  output  1  vld[DEPTH-1]
- occ_o  output  $clog2(DEPTH+1)  count of set vld bits (registered)

Behaviour:
- State: stage[0..DEPTH-1] (CH*WIDTH bits each), vld[0..DEPTH-1], occ register. All updates on the same edge; every next-state value derives from pre-edge values.
- Priority at each rising edge: rst_n==0 > flush_i==1 > en_i==0 > mode_i.
- Reset: all stages 0, vld 0, occ 0. data_o=0, valid_o=0, occ_o=0 after the edge. Reset mid-operation discards everything. No partial state survives.
- Flush: same clear as reset. Acts regardless of en_i.
- en_i==0 or mode HOLD: all state unchanged.
- SHIFT:
  - stage[0]<=data_i, vld[0]<=valid_i. For k>=1: stage[k]<=stage[k-1], vld[k]<=vld[k-1].
  - data_i is captured even when valid_i==0; its vld is 0.
  - Latency: data_i sampled at edge n appears on data_o after edge n+DEPTH-1 (i.e. visible DEPTH-1 cycles after capture; DEPTH=1 means visible right after the capturing edge).
  - occ <= occ + valid_i - vld[DEPTH-1]. Never over/underflows because it is bounded by DEPTH.
- RECIRC:
  - stage[0]<=stage[DEPTH-1], vld[0]<=vld[DEPTH-1]. Other stages shift as in SHIFT.
  - data_i and valid_i are ignored. occ unchanged.
  - DEPTH=1: stage holds its value.
- SWAP:
  - Each stage rotates channels in place: ch[c]<=ch[(c+1) mod CH].
  - vld unchanged, occ unchanged, data_i ignored.
  - CH=2 is an a/b swap. CH=1 is a no-op.
- Mode changes take effect at the next edge with no bubble or extra latency.
- Outputs have no combinational path from any input.

Decomposition:
- Package nb_chain_pkg holds:
  - mode constants MODE_SHIFT=2'b00, MODE_RECIRC=2'b01, MODE_SWAP=2'b10, MODE_HOLD=2'b11
  - a 2-bit mode typedef
- Sub-module nb_chain_stage: one stage register plus vld bit.
  - Input mux selects between the shift source and its own channel-rotated value.
  - Inputs: enable, clear.
  - Instantiated DEPTH times. The top handles ring feedback, priority decode and occ.

Test Plan:
1. Reset: rst_n=0 for 2 edges with data_i=all ones, valid_i=1, en_i=1 -> data_o=0, valid_o=0, occ_o=0. Release -> normal operation resumes on the next edge.
2. SHIFT latency (WIDTH=1, CH=2, DEPTH=2): data_i=2'b01, valid_i=1 for one edge, then valid_i=0 -> after edge 2, data_o=2'b01 and valid_o=1. occ_o sequence: 1, 1, 0.
3. SWAP (WIDTH=4, CH=3): stage holds {ch2,ch1,ch0}={1,3,2} in hex... load {3,2,1} via SHIFT, then one SWAP edge -> data_o={1,3,2}. Two more SWAP edges -> {3,2,1}. vld and occ_o unchanged throughout.
4. RECIRC (DEPTH=4): shift in 1,2,3,4 all valid (data_o=1, occ_o=4), switch to RECIRC -> data_o sequence 2,3,4,1,2... with period 4. occ_o stays 4 and valid_o stays 1.
5. Hold/flush: en_i=0 for 3 edges -> state frozen. flush_i=1 with en_i=0 -> all cleared, occ_o=0. flush_i=1 and rst_n=0 together -> reset result.
6. Reset mid-stream: DEPTH=4 SHIFT with occ_o=3, rst_n=0 for one edge -> data_o=0, valid_o=0, occ_o=0. A new input after release emerges with full DEPTH latency.
